eth_buf_rd_stream: RTL and testbench

ETH_BUF_RD_STREAM -- requirements
Module: eth_buf_rd_stream

---
 rtl/eth_buf_rd_stream_if.sv | 30 +++
 rtl/eth_buf_rd_stream.sv | 132 +++++++++++++
 tb/tb_eth_buf_rd_stream.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_buf_rd_stream_if.sv
// Handshake and buffer-port bundle for the buffer-to-DMA read streamer.
// master: the streamer itself; slave: the buffer/DMA side driving it.
interface eth_buf_rd_stream_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  length;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              ready;
    logic              last;
    logic              busy;
    logic              done;

    modport master (
        input  start, start_addr, length, mem_data, ready,
        output mem_en, mem_addr, data_out, valid, last, busy, done
    );

    modport slave (
        output start, start_addr, length, mem_data, ready,
        input  mem_en, mem_addr, data_out, valid, last, busy, done
    );
endinterface

// File: rtl/eth_buf_rd_stream.sv
// Streams a run of words out of a one-cycle-latency buffer into a
// valid/ready DMA port through a 4-entry FIFO.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for start; zero-length start just pulses done
//  READ  | issuing buffer reads, throttled by FIFO room
//  DRAIN | all reads issued; waiting for the final word handshake
module eth_buf_rd_stream #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    eth_buf_rd_stream_if.master  bus
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state;
    logic [LEN_W-1:0]  rd_left;
    logic [LEN_W-1:0]  out_left;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_pend;
    logic              busy_q;
    logic              done_q;

    logic [DATA_W-1:0] fifo_mem [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        fifo_cnt;

    logic [2:0]        occ;
    logic              issue;
    logic              push;
    logic              pop;

    // A read issued last cycle has not landed yet, so it reserves a slot.
    assign occ   = fifo_cnt + {2'b00, rd_pend};
    assign issue = (state == READ) && (rd_left != '0) && (occ < 3'd4);
    assign push  = rd_pend;
    assign pop   = bus.valid && bus.ready;

    assign bus.mem_en   = issue;
    assign bus.mem_addr = rd_addr;
    assign bus.valid    = (fifo_cnt != 3'd0);
    assign bus.data_out = fifo_mem[rd_ptr];
    assign bus.last     = bus.valid && (out_left == LEN_W'(1));
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    // Sequencer: transfer setup, read issue bookkeeping and completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_left  <= '0;
            out_left <= '0;
            rd_addr  <= '0;
            rd_pend  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            rd_pend <= issue;
            if (issue) begin
                rd_addr <= rd_addr + ADDR_W'(1);
                rd_left <= rd_left - LEN_W'(1);
            end
            if (pop) begin
                out_left <= out_left - LEN_W'(1);
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.length != '0) begin
                            state    <= READ;
                            rd_addr  <= bus.start_addr;
                            rd_left  <= bus.length;
                            out_left <= bus.length;
                            busy_q   <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue && (rd_left == LEN_W'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (out_left == LEN_W'(1))) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Read-data FIFO: capture the word returned for last cycle's read, pop on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.mem_data;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_buf_rd_stream.sv
// Bench for eth_buf_rd_stream: behavioural buffer plus a transfer-level
// model (words issued / words delivered) checked every cycle.
module tb_eth_buf_rd_stream;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    logic [DATA_W-1:0] buf_mem [DEPTH];
    int                pat [10] = '{1, 0, 1, 1, 1, 1, 1, 0, 0, 0};

    eth_buf_rd_stream_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    eth_buf_rd_stream #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer: data for a read appears the cycle after mem_en, garbage otherwise.
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_data <= buf_mem[bus.mem_addr];
        else            bus.mem_data <= $urandom;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic fill_index();
        for (int i = 0; i < DEPTH; i++) buf_mem[i] = DATA_W'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) buf_mem[i] = $urandom;
    endtask

    // Entered at a falling edge; start is presented for the coming rising edge.
    // rmode: 0 ready=1, 1 fixed pattern, 2 random. abort_after>=0 asserts rst after that many words.
    task automatic run_xfer(input int s_addr, input int len, input int rmode,
                            input int abort_after, input bit spur);
        int issued  = 0;
        int popped  = 0;
        int iss_old = 0;
        int c       = 0;
        int exp_addr;
        bit exp_en, exp_valid, exp_last, exp_done, exp_busy, r, hs;
        bit stall_prev = 0;
        logic [DATA_W-1:0] exp_data;
        logic [DATA_W-1:0] data_prev = '0;

        bus.start      = 1'b1;
        bus.start_addr = ADDR_W'(s_addr);
        bus.length     = LEN_W'(len);
        bus.ready      = 1'b0;
        forever begin
            @(negedge clk);
            bus.start = 1'b0;
            c++;
            if (c > len * 12 + 40) begin
                miscompares++;
                $display("FAIL timeout addr=%0d len=%0d got=%0d cycles exp<=%0d", s_addr, len, c, len * 12 + 40);
                break;
            end
            exp_done  = (popped == len);
            exp_busy  = !exp_done;
            exp_en    = (issued < len) && (issued - popped < 4);
            exp_addr  = (s_addr + issued) % DEPTH;
            exp_valid = (iss_old - popped) > 0;
            exp_data  = buf_mem[(s_addr + popped) % DEPTH];
            exp_last  = exp_valid && (popped == len - 1);

            vectors++;
            if (bus.mem_en !== exp_en) begin
                miscompares++;
                $display("FAIL mem_en cyc=%0d got=%b exp=%b", c, bus.mem_en, exp_en);
            end
            if (exp_en) begin
                vectors++;
                if (bus.mem_addr !== ADDR_W'(exp_addr)) begin
                    miscompares++;
                    $display("FAIL mem_addr cyc=%0d got=%0d exp=%0d", c, bus.mem_addr, exp_addr);
                end
            end
            vectors++;
            if (bus.valid !== exp_valid) begin
                miscompares++;
                $display("FAIL valid cyc=%0d got=%b exp=%b", c, bus.valid, exp_valid);
            end
            if (exp_valid) begin
                vectors++;
                if (bus.data_out !== exp_data) begin
                    miscompares++;
                    $display("FAIL data_out cyc=%0d word=%0d got=%0h exp=%0h", c, popped, bus.data_out, exp_data);
                end
            end
            if (stall_prev) begin
                vectors++;
                if (bus.data_out !== data_prev || bus.valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_hold cyc=%0d got=%0h/%b exp=%0h/1", c, bus.data_out, bus.valid, data_prev);
                end
            end
            vectors++;
            if (bus.last !== exp_last) begin
                miscompares++;
                $display("FAIL last cyc=%0d got=%b exp=%b", c, bus.last, exp_last);
            end
            vectors++;
            if (bus.busy !== exp_busy) begin
                miscompares++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", c, bus.busy, exp_busy);
            end
            vectors++;
            if (bus.done !== exp_done) begin
                miscompares++;
                $display("FAIL done cyc=%0d got=%b exp=%b", c, bus.done, exp_done);
            end
            if (exp_done) break;

            case (rmode)
                0:       r = 1'b1;
                1:       r = pat[(c - 1) % 10] != 0;
                default: r = ($urandom % 3) != 0;
            endcase
            bus.ready = r;
            if (spur && ($urandom % 4 == 0)) begin
                bus.start      = 1'b1;
                bus.start_addr = ADDR_W'($urandom);
                bus.length     = LEN_W'($urandom % 8);
            end
            hs         = exp_valid && r;
            stall_prev = exp_valid && !r;
            data_prev  = bus.data_out;
            iss_old    = issued;
            if (exp_en) issued++;
            if (hs) popped++;

            if (abort_after >= 0 && popped == abort_after) begin
                #1 rst = 1'b1;
                #1;
                vectors++;
                if ({bus.mem_en, bus.valid, bus.last, bus.busy, bus.done} !== 5'b0) begin
                    miscompares++;
                    $display("FAIL abort_ctrl got=%b exp=00000", {bus.mem_en, bus.valid, bus.last, bus.busy, bus.done});
                end
                vectors++;
                if (bus.mem_addr !== '0 || bus.data_out !== '0) begin
                    miscompares++;
                    $display("FAIL abort_bus got=%0h/%0h exp=0/0", bus.mem_addr, bus.data_out);
                end
                bus.start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                break;
            end
        end
        bus.ready = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.length     = '0;
        bus.ready      = 1'b0;
        #3;
        vectors++;
        if ({bus.mem_en, bus.valid, bus.last, bus.busy, bus.done} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b exp=00000", {bus.mem_en, bus.valid, bus.last, bus.busy, bus.done});
        end
        vectors++;
        if (bus.mem_addr !== '0 || bus.data_out !== '0) begin
            miscompares++;
            $display("FAIL reset_bus got=%0h/%0h exp=0/0", bus.mem_addr, bus.data_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_long_stream();
        fill_index();
        run_xfer(0, 1000, 0, -1, 0);
    endtask

    task automatic test_backpressure();
        fill_random();
        run_xfer(int'($urandom % DEPTH), 16, 1, -1, 0);
        @(negedge clk);
        run_xfer(int'($urandom % DEPTH), 37, 2, -1, 0);
    endtask

    task automatic test_wrap();
        run_xfer(2046, 4, 0, -1, 0);
        @(negedge clk);
        run_xfer(2045, 9, 2, -1, 0);
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        run_xfer(int'($urandom % DEPTH), 0, 0, -1, 0);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_after got=%b%b%b exp=000", bus.valid, bus.busy, bus.done);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        run_xfer(300, 100, 0, 5, 0);
        run_xfer(10, 3, 0, -1, 0);
    endtask

    task automatic test_start_while_busy();
        @(negedge clk);
        run_xfer(500, 40, 2, -1, 1);
        @(negedge clk);
        run_xfer(1900, 200, 0, -1, 1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) begin
            if (k % 3 == 0) fill_random();
            run_xfer(int'($urandom % DEPTH), int'($urandom_range(1, 50)), int'($urandom % 3), -1, k[0]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_long_stream();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_mid_reset();
        test_start_while_busy();
        test_back_to_back();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
